// File: rtl/aurora_data_controller.sv
// aurora_pkg: shared width and ordered-set encoding for the Aurora framing path.
package aurora_pkg;
   localparam int unsigned AXI_DATA_SIZE = 64;

   typedef enum logic [1:0] {
      OS_IDLE = 2'd0,
      OS_SCP  = 2'd1,
      OS_DATA = 2'd2,
      OS_ECP  = 2'd3
   } ordered_sets_e;
endpackage

// aurora_data_controller: samples user words into a 4-entry FIFO and frames
// them as SCP / DATA... / ECP symbols, one symbol per engine step (2 clk).
module aurora_data_controller
   import aurora_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     single_lane,
   input  logic                     axi_valid,
   input  logic                     axi_last,
   input  logic [AXI_DATA_SIZE-1:0] axi_data,
   output ordered_sets_e            ordered_sets,
   output logic [AXI_DATA_SIZE-1:0] data_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_END  = 2'd2
   } state_e;

   logic [2:0]             phase_q, phase_d;
   logic                   step;
   logic                   sample;
   logic                   push;
   logic                   pop;

   logic [AXI_DATA_SIZE:0] mem_q [4];
   logic [AXI_DATA_SIZE:0] mem_d [4];
   logic [AXI_DATA_SIZE:0] head;
   logic [1:0]             wr_ptr_q, wr_ptr_d;
   logic [1:0]             rd_ptr_q, rd_ptr_d;
   logic [2:0]             count_q, count_d;

   state_e                 state_q, state_d;
   ordered_sets_e          os_q, os_d;
   logic [AXI_DATA_SIZE-1:0] data_q, data_d;

   assign head         = mem_q[rd_ptr_q];
   assign ordered_sets = os_q;
   assign data_out     = data_q;

   // Phase counter and strobes; a full FIFO (by registered count) drops the word.
   always_comb begin
      phase_d = phase_q + 3'd1;
      step    = phase_q[0];
      sample  = single_lane ? (phase_q == 3'd7) : step;
      push    = sample && axi_valid && (count_q != 3'd4);
   end

   // FIFO next state; a pop only ever sees entries counted before this edge.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {axi_last, axi_data};
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
   end

   // Framing FSM: next state and registered symbol, updated only on step strobes.
   always_comb begin
      state_d = state_q;
      os_d    = os_q;
      data_d  = data_q;
      pop     = 1'b0;
      if (step) begin
         os_d   = OS_IDLE;
         data_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (count_q != 3'd0) begin
                  os_d    = OS_SCP;
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (count_q != 3'd0) begin
                  pop    = 1'b1;
                  os_d   = OS_DATA;
                  data_d = head[AXI_DATA_SIZE-1:0];
                  if (head[AXI_DATA_SIZE]) begin
                     state_d = ST_END;
                  end
               end
            end
            ST_END: begin
               os_d    = OS_ECP;
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Phase and FIFO bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         phase_q  <= phase_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   // FSM state and output symbol registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         os_q    <= OS_IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         os_q    <= os_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_aurora_data_controller.sv
// Scoreboard bench for aurora_data_controller: stimulus queues the expected
// framed symbols, a monitor compares every symbol belonging to a frame.
`timescale 1ns/1ps
module tb_aurora_data_controller;
   import aurora_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          single_lane = 1'b0;
   logic          axi_valid = 1'b0;
   logic          axi_last = 1'b0;
   logic [63:0]   axi_data = '0;
   ordered_sets_e ordered_sets;
   logic [63:0]   data_out;

   typedef struct packed {
      ordered_sets_e os;
      logic [63:0]   data;
   } sym_t;

   sym_t       exp_q[$];
   sym_t       mon_exp;
   int         total = 0;
   int         bad = 0;
   logic       mon_en = 1'b0;
   bit         in_frame = 1'b0;
   bit         after_ecp = 1'b0;
   logic [2:0] tb_phase;

   aurora_data_controller dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .single_lane  (single_lane),
      .axi_valid    (axi_valid),
      .axi_last     (axi_last),
      .axi_data     (axi_data),
      .ordered_sets (ordered_sets),
      .data_out     (data_out)
   );

   // 400 MHz clock
   always #1.25 clk = ~clk;

   // Bench-side phase so stimulus can line up with step and sample edges
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_phase <= 3'd0;
      else        tb_phase <= tb_phase + 3'd1;
   end

   // Monitor: after each step edge, compare symbols inside a frame and the one after ECP
   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame  = 1'b0;
         after_ecp = 1'b0;
      end else if (mon_en && !tb_phase[0]) begin
         if (ordered_sets != OS_IDLE || in_frame || after_ecp) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_symbol: got os=%0d data=%h, required no symbol", ordered_sets, data_out);
            end else begin
               mon_exp = exp_q.pop_front();
               if (ordered_sets !== mon_exp.os || data_out !== mon_exp.data) begin
                  bad++;
                  $display("FAIL symbol: got os=%0d data=%h, required os=%0d data=%h",
                           ordered_sets, data_out, mon_exp.os, mon_exp.data);
               end
            end
            after_ecp = (ordered_sets == OS_ECP);
            if (ordered_sets == OS_SCP)      in_frame = 1'b1;
            else if (ordered_sets == OS_ECP) in_frame = 1'b0;
         end else begin
            total++;
            if (data_out !== 64'd0) begin
               bad++;
               $display("FAIL idle_data: got %h, required 0", data_out);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push_exp(input ordered_sets_e os, input logic [63:0] d);
      sym_t s;
      s.os   = os;
      s.data = d;
      exp_q.push_back(s);
   endtask

   // Return just after the next step edge
   task automatic at_step();
      do @(negedge clk); while (!tb_phase[0]);
      @(posedge clk);
      #0.2;
   endtask

   // Return just after the next phase-7 edge (single-lane sample edge)
   task automatic at_sample7();
      do @(negedge clk); while (tb_phase != 3'd7);
      @(posedge clk);
      #0.2;
   endtask

   task automatic steps(input int n);
      repeat (n) at_step();
   endtask

   task automatic drive(input logic v, input logic l, input logic [63:0] d);
      axi_valid = v;
      axi_last  = l;
      axi_data  = d;
   endtask

   initial begin
      // Reset values
      #3;
      check("reset_os", ordered_sets, OS_IDLE);
      check("reset_data", data_out, 64'd0);
      #6.5 rst_n = 1'b1;
      mon_en = 1'b1;
      steps(4);

      // Dual-lane one-word frame
      push_exp(OS_SCP, 64'd0);
      push_exp(OS_DATA, 64'hDEADB00DDEADB00D);
      push_exp(OS_ECP, 64'd0);
      push_exp(OS_IDLE, 64'd0);
      drive(1'b1, 1'b1, 64'hDEADB00DDEADB00D);
      at_step();
      drive(1'b0, 1'b0, 64'd0);
      steps(6);

      // Dual-lane 7-period frame with a 3-period gap
      push_exp(OS_SCP, 64'd0);
      push_exp(OS_DATA, 64'hB0B0000000000000);
      push_exp(OS_DATA, 64'hB0B0000000000001);
      push_exp(OS_IDLE, 64'd0);
      push_exp(OS_IDLE, 64'd0);
      push_exp(OS_DATA, 64'hB0B0000000000005);
      push_exp(OS_DATA, 64'hB0B0000000000006);
      push_exp(OS_ECP, 64'd0);
      push_exp(OS_IDLE, 64'd0);
      for (int p = 0; p < 7; p++) begin
         drive((p < 2) || (p > 4), p == 6, 64'hB0B0000000000000 | 64'(p));
         at_step();
      end
      drive(1'b0, 1'b0, 64'd0);
      steps(8);

      // Reset in the middle of a frame
      push_exp(OS_SCP, 64'd0);
      push_exp(OS_DATA, 64'h0123456789ABCDEF);
      drive(1'b1, 1'b0, 64'h0123456789ABCDEF);
      at_step();
      at_step();
      at_step();
      #1.8;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 64'd0);
      #1;
      check("midreset_os", ordered_sets, OS_IDLE);
      check("midreset_data", data_out, 64'd0);
      check("midreset_queue", 64'(exp_q.size()), 64'd0);
      #9 rst_n = 1'b1;
      steps(8);
      check("flushed_os", ordered_sets, OS_IDLE);

      // Single-lane: valid held only across phase 1/3/5 steps must not be sampled
      single_lane = 1'b1;
      at_sample7();
      drive(1'b1, 1'b1, 64'hBAD0BAD0BAD0BAD0);
      steps(3);
      drive(1'b0, 1'b0, 64'd0);
      steps(4);
      check("no_push_os", ordered_sets, OS_IDLE);

      // Single-lane back-to-back frames and sample-to-SCP latency
      push_exp(OS_SCP, 64'd0);
      push_exp(OS_DATA, 64'hAAAA00000000000A);
      push_exp(OS_ECP, 64'd0);
      push_exp(OS_IDLE, 64'd0);
      push_exp(OS_SCP, 64'd0);
      push_exp(OS_DATA, 64'hBBBB0000000000B0);
      push_exp(OS_IDLE, 64'd0);
      push_exp(OS_IDLE, 64'd0);
      push_exp(OS_DATA, 64'hBBBB0000000000B1);
      push_exp(OS_ECP, 64'd0);
      push_exp(OS_IDLE, 64'd0);
      at_sample7();
      drive(1'b1, 1'b1, 64'hAAAA00000000000A);
      at_sample7();
      drive(1'b1, 1'b0, 64'hBBBB0000000000B0);
      @(posedge clk);
      #0.2;
      check("lat_1clk_os", ordered_sets, OS_IDLE);
      @(posedge clk);
      #0.2;
      check("lat_2clk_os", ordered_sets, OS_SCP);
      at_sample7();
      drive(1'b1, 1'b1, 64'hBBBB0000000000B1);
      at_sample7();
      drive(1'b0, 1'b0, 64'd0);
      steps(12);
      single_lane = 1'b0;

      // Dual-lane overflow: 8 back-to-back one-word frames, words 5 and 7 dropped
      for (int k = 0; k < 8; k++) begin
         if (k == 5 || k == 7) continue;
         push_exp(OS_SCP, 64'd0);
         push_exp(OS_DATA, 64'hF00D000000000000 | 64'(k));
         push_exp(OS_ECP, 64'd0);
      end
      push_exp(OS_IDLE, 64'd0);
      at_step();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b1, 64'hF00D000000000000 | 64'(k));
         at_step();
      end
      drive(1'b0, 1'b0, 64'd0);
      steps(24);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
